// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : MEM pipeline stage plus MEM/WB register. Resolves branches
//             (pc_src/flush_out/branch_target) and runs loads and stores
//             through a req/ack data-memory port. Upstream stages are stalled
//             while an access is in flight. Misaligned accesses and bus
//             timeouts are reported as a one-cycle mem_fault pulse.
//  Ports    : clk, rst_n (async, active low)
//             EX/MEM inputs : *_in controls, ALU result/address, store data,
//                             ALU_OP_in {funct7[5],funct3}, dest_reg_in
//             Memory port   : dmem_req/we/addr/wdata/be out, dmem_rdata/ack in
//             Hazard/branch : stall_out, pc_src, branch_target, flush_out
//             Status        : mem_fault
//             MEM/WB        : RegWrite_wb, MemtoReg_wb, read_data_wb,
//                             ALU_result_wb, dest_reg_wb
//  Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage #(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RegWrite_in,
   input  logic            MemtoReg_in,
   input  logic            Branch_in,
   input  logic            Zero_in,
   input  logic            is_greater_in,
   input  logic            MemWrite_in,
   input  logic            MemRead_in,
   input  logic [XLEN-1:0] immvalue_added_pc_in,
   input  logic [XLEN-1:0] ALU_result_in,
   input  logic [XLEN-1:0] WriteData_in,
   input  logic [3:0]      ALU_OP_in,
   input  logic [4:0]      dest_reg_in,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [7:0]      dmem_be,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic            stall_out,
   output logic            pc_src,
   output logic [XLEN-1:0] branch_target,
   output logic            flush_out,
   output logic            mem_fault,
   output logic            RegWrite_wb,
   output logic            MemtoReg_wb,
   output logic [XLEN-1:0] read_data_wb,
   output logic [XLEN-1:0] ALU_result_wb,
   output logic [4:0]      dest_reg_wb
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic              killed;
   logic [XLEN-1:0]   rdata_q;

   logic [2:0]        funct3;
   logic [1:0]        size;
   logic [2:0]        addr_lo;
   logic              mem_op;
   logic              misaligned;
   logic              br_cond;
   logic              taken;
   logic              stall_c;
   logic              timeout_c;
   logic [7:0]        be_mask;
   logic [XLEN-1:0]   lane;
   logic [XLEN-1:0]   load_ext;
   logic              unused_funct7;

   assign funct3        = ALU_OP_in[2:0];
   assign size          = funct3[1:0];
   assign addr_lo       = ALU_result_in[2:0];
   assign mem_op        = MemRead_in | MemWrite_in;
   assign unused_funct7 = ALU_OP_in[3];

   always_comb begin
      misaligned = 1'b0;
      be_mask    = 8'h01;
      case (size)
         2'd0: begin misaligned = 1'b0;             be_mask = 8'h01; end
         2'd1: begin misaligned = addr_lo[0];       be_mask = 8'h03; end
         2'd2: begin misaligned = |addr_lo[1:0];    be_mask = 8'h0F; end
         default: begin misaligned = |addr_lo;      be_mask = 8'hFF; end
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  br_cond = Zero_in;
         3'b001:  br_cond = ~Zero_in;
         3'b100:  br_cond = ~is_greater_in & ~Zero_in;
         3'b101:  br_cond = is_greater_in | Zero_in;
         default: br_cond = 1'b0;
      endcase
   end

   // A memory op always wins over a (malformed) simultaneous branch.
   assign taken = (state == S_IDLE) & Branch_in & ~mem_op & br_cond;

   // Combinational outputs are forced low while reset is asserted so that
   // every output reads zero during reset, not only the registered ones.
   assign pc_src        = rst_n & taken;
   assign flush_out     = rst_n & taken;
   assign stall_out     = rst_n & stall_c;
   assign branch_target = rst_n ? immvalue_added_pc_in : '0;

   // Select the addressed lane, then sign/zero extend by access size.
   assign lane = dmem_rdata >> {addr_lo, 3'b000};
   always_comb begin
      case (size)
         2'd0: load_ext = funct3[2] ? {{(XLEN-8){1'b0}},  lane[7:0]}
                                    : {{(XLEN-8){lane[7]}}, lane[7:0]};
         2'd1: load_ext = funct3[2] ? {{(XLEN-16){1'b0}},   lane[15:0]}
                                    : {{(XLEN-16){lane[15]}}, lane[15:0]};
         2'd2: load_ext = funct3[2] ? {{(XLEN-32){1'b0}},   lane[31:0]}
                                    : {{(XLEN-32){lane[31]}}, lane[31:0]};
         default: load_ext = lane;
      endcase
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_c   = 1'b0;
      timeout_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_op && !misaligned) begin
               stall_c   = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            stall_c = 1'b1;
            if (dmem_ack) begin
               state_nxt = S_RESP;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               timeout_c = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------ datapath / MEM/WB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         killed        <= 1'b0;
         rdata_q       <= '0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_be       <= '0;
         mem_fault     <= 1'b0;
         RegWrite_wb   <= 1'b0;
         MemtoReg_wb   <= 1'b0;
         read_data_wb  <= '0;
         ALU_result_wb <= '0;
         dest_reg_wb   <= '0;
      end else begin
         // Default: MEM/WB takes a bubble and fault is a single-cycle pulse.
         mem_fault     <= 1'b0;
         RegWrite_wb   <= 1'b0;
         MemtoReg_wb   <= 1'b0;
         read_data_wb  <= '0;
         ALU_result_wb <= '0;
         dest_reg_wb   <= '0;
         case (state)
            S_IDLE: begin
               cnt    <= '0;
               killed <= 1'b0;
               if (mem_op) begin
                  if (misaligned) begin
                     mem_fault <= 1'b1;
                  end else begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= MemWrite_in;
                     dmem_addr  <= ALU_result_in;
                     dmem_wdata <= WriteData_in << {addr_lo, 3'b000};
                     dmem_be    <= be_mask << addr_lo;
                  end
               end else begin
                  RegWrite_wb   <= RegWrite_in & ~Branch_in;
                  MemtoReg_wb   <= MemtoReg_in;
                  ALU_result_wb <= ALU_result_in;
                  dest_reg_wb   <= dest_reg_in;
               end
            end
            S_WAIT: begin
               if (dmem_ack) begin
                  rdata_q  <= load_ext;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  dmem_be  <= '0;
               end else if (timeout_c) begin
                  killed    <= 1'b1;
                  mem_fault <= 1'b1;
                  dmem_req  <= 1'b0;
                  dmem_we   <= 1'b0;
                  dmem_be   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RESP: begin
               // EX/MEM was held by the stall, so *_in still describe the access.
               RegWrite_wb   <= RegWrite_in & ~killed;
               MemtoReg_wb   <= MemtoReg_in & ~killed;
               read_data_wb  <= killed ? '0 : rdata_q;
               ALU_result_wb <= ALU_result_in;
               dest_reg_wb   <= dest_reg_in;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Purpose  : Directed self-checking bench for mem_wb_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;
   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            RegWrite_in, MemtoReg_in, Branch_in, Zero_in, is_greater_in;
   logic            MemWrite_in, MemRead_in;
   logic [XLEN-1:0] immvalue_added_pc_in, ALU_result_in, WriteData_in;
   logic [3:0]      ALU_OP_in;
   logic [4:0]      dest_reg_in;
   logic            dmem_req, dmem_we;
   logic [XLEN-1:0] dmem_addr, dmem_wdata;
   logic [7:0]      dmem_be;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ack;
   logic            stall_out, pc_src, flush_out, mem_fault;
   logic [XLEN-1:0] branch_target;
   logic            RegWrite_wb, MemtoReg_wb;
   logic [XLEN-1:0] read_data_wb, ALU_result_wb;
   logic [4:0]      dest_reg_wb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_wb_stage #(.XLEN(XLEN), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
      .Zero_in(Zero_in), .is_greater_in(is_greater_in), .MemWrite_in(MemWrite_in),
      .MemRead_in(MemRead_in), .immvalue_added_pc_in(immvalue_added_pc_in),
      .ALU_result_in(ALU_result_in), .WriteData_in(WriteData_in),
      .ALU_OP_in(ALU_OP_in), .dest_reg_in(dest_reg_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .stall_out(stall_out), .pc_src(pc_src),
      .branch_target(branch_target), .flush_out(flush_out), .mem_fault(mem_fault),
      .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
      .read_data_wb(read_data_wb), .ALU_result_wb(ALU_result_wb),
      .dest_reg_wb(dest_reg_wb)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample/drive 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      RegWrite_in = 0; MemtoReg_in = 0; Branch_in = 0; Zero_in = 0;
      is_greater_in = 0; MemWrite_in = 0; MemRead_in = 0;
      immvalue_added_pc_in = '0; ALU_result_in = '0; WriteData_in = '0;
      ALU_OP_in = '0; dest_reg_in = '0; dmem_rdata = '0; dmem_ack = 0;
   endtask

   initial begin
      nop();
      rst_n = 0;
      step(); step();
      // ---- reset state
      chk("rst_req",   dmem_req, 0);
      chk("rst_stall", stall_out, 0);
      chk("rst_rw",    RegWrite_wb, 0);
      chk("rst_fault", mem_fault, 0);
      rst_n = 1;
      step();

      // ---- 1: plain ALU op
      RegWrite_in = 1; ALU_result_in = 64'h1234; dest_reg_in = 5;
      #1 chk("alu_stall", stall_out, 0);
      step();
      chk("alu_rw",   RegWrite_wb, 1);
      chk("alu_res",  ALU_result_wb, 64'h1234);
      chk("alu_rd",   dest_reg_wb, 5);
      chk("alu_stall2", stall_out, 0);
      nop();

      // ---- 2: LB at 0x1003, ack in 2nd WAIT cycle
      MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1; ALU_OP_in = 4'b0000;
      ALU_result_in = 64'h1003; dest_reg_in = 7;
      #1 chk("lb_stall0", stall_out, 1);
      chk("lb_noreq0", dmem_req, 0);
      step();
      chk("lb_req",   dmem_req, 1);
      chk("lb_we",    dmem_we, 0);
      chk("lb_addr",  dmem_addr, 64'h1003);
      chk("lb_be",    dmem_be, 8'h08);
      chk("lb_bub",   RegWrite_wb, 0);
      chk("lb_stall1", stall_out, 1);
      step();
      chk("lb_stall2", stall_out, 1);
      dmem_ack = 1; dmem_rdata = 64'h0000_0000_8000_0000;
      step();
      dmem_ack = 0; dmem_rdata = '0;
      chk("lb_stall3", stall_out, 0);
      chk("lb_reqdrop", dmem_req, 0);
      step();
      nop();
      chk("lb_rw",   RegWrite_wb, 1);
      chk("lb_m2r",  MemtoReg_wb, 1);
      chk("lb_data", read_data_wb, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_rd",   dest_reg_wb, 7);

      // ---- LHU at 0x1002, minimum latency (ack in first WAIT cycle)
      MemRead_in = 1; RegWrite_in = 1; ALU_OP_in = 4'b0101;
      ALU_result_in = 64'h1002; dest_reg_in = 9;
      step();
      chk("lhu_be", dmem_be, 8'h0C);
      dmem_ack = 1; dmem_rdata = 64'h0000_0000_ABCD_0000;
      step();
      dmem_ack = 0;
      step();
      nop();
      chk("lhu_data", read_data_wb, 64'h0000_0000_0000_ABCD);
      chk("lhu_rw",   RegWrite_wb, 1);

      // ---- 3: SH at 0x1006
      MemWrite_in = 1; ALU_OP_in = 4'b0001; ALU_result_in = 64'h1006;
      WriteData_in = 64'hBEEF;
      step();
      chk("sh_be",    dmem_be, 8'hC0);
      chk("sh_wdata", dmem_wdata, 64'hBEEF_0000_0000_0000);
      chk("sh_we",    dmem_we, 1);
      step();
      chk("sh_we2",   dmem_we, 1);
      chk("sh_req2",  dmem_req, 1);
      dmem_ack = 1;
      step();
      dmem_ack = 0;
      chk("sh_weoff", dmem_we, 0);
      step();
      nop();
      chk("sh_rw", RegWrite_wb, 0);

      // ---- 4a: misaligned LW at 0x1002
      MemRead_in = 1; RegWrite_in = 1; ALU_OP_in = 4'b0010; ALU_result_in = 64'h1002;
      #1 chk("mis_stall", stall_out, 0);
      step();
      nop();
      chk("mis_req",   dmem_req, 0);
      chk("mis_fault", mem_fault, 1);
      chk("mis_rw",    RegWrite_wb, 0);
      step();
      chk("mis_fault_end", mem_fault, 0);

      // ---- 4b: LD at 0x2000 with no ack -> timeout after 16 WAIT cycles
      MemRead_in = 1; RegWrite_in = 1; ALU_OP_in = 4'b0011; ALU_result_in = 64'h2000;
      step();
      for (int i = 0; i < 15; i++) step();
      chk("to_req_held", dmem_req, 1);
      chk("to_nofault",  mem_fault, 0);
      step();
      chk("to_fault",   mem_fault, 1);
      chk("to_reqdrop", dmem_req, 0);
      chk("to_stall",   stall_out, 0);
      step();
      nop();
      chk("to_rw",     RegWrite_wb, 0);
      chk("to_fault2", mem_fault, 0);

      // ---- 5: branches
      Branch_in = 1; RegWrite_in = 1; ALU_OP_in = 4'b0001; Zero_in = 0;
      immvalue_added_pc_in = 64'hDEAD_BEEF;
      #1 chk("bne_pc",    pc_src, 1);
      chk("bne_flush", flush_out, 1);
      chk("bne_tgt",   branch_target, 64'hDEAD_BEEF);
      step();
      chk("bne_rw", RegWrite_wb, 0);
      ALU_OP_in = 4'b0000;
      #1 chk("beq_pc", pc_src, 0);
      ALU_OP_in = 4'b0100;
      #1 chk("blt_pc", pc_src, 1);
      ALU_OP_in = 4'b0101;
      #1 chk("bge_pc", pc_src, 0);
      is_greater_in = 1;
      #1 chk("bge_gt_pc", pc_src, 1);
      ALU_OP_in = 4'b0010;
      #1 chk("bx_pc", pc_src, 0);
      ALU_OP_in = 4'b0001; MemRead_in = 1; ALU_result_in = 64'h3000;
      #1 chk("simul_pc", pc_src, 0);
      nop();
      step();

      // ---- 6: reset mid-WAIT
      MemRead_in = 1; RegWrite_in = 1; ALU_OP_in = 4'b0000; ALU_result_in = 64'h3000;
      step();
      chk("rw_req", dmem_req, 1);
      #2 rst_n = 0;
      #1 chk("rw_req0",   dmem_req, 0);
      chk("rw_stall0", stall_out, 0);
      chk("rw_be0",    dmem_be, 0);
      chk("rw_addr0",  dmem_addr, 0);
      chk("rw_pc0",    pc_src, 0);
      nop();
      step();
      rst_n = 1;
      step();
      chk("rw_idle_stall", stall_out, 0);
      chk("rw_idle_req",   dmem_req, 0);
      // ack outside WAIT must be ignored
      dmem_ack = 1; RegWrite_in = 1; ALU_result_in = 64'h55; dest_reg_in = 3;
      step();
      dmem_ack = 0;
      chk("stray_ack_res", ALU_result_wb, 64'h55);
      chk("stray_ack_req", dmem_req, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
